// File: rtl/semaforo_monitor.sv
// Passive safety checker for the two-way traffic-light controller outputs.
// Optional dwell-time (TIME) checking is compiled in when MON_TIMING_EN is defined.
module semaforo_monitor #(
   parameter int unsigned YELLOW_CYCLES = 3,
   parameter int unsigned MIN_GREEN     = 5,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ENB,
   input  logic [1:0]       Semaforo_A,
   input  logic [1:0]       Semaforo_B,
   input  logic             A_Peatonal,
   input  logic             B_Peatonal,
   input  logic             clr_err,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [4:0]       err_vec,
   output logic [CNT_W-1:0] cycles_A
);

   typedef enum logic [1:0] {
      RED     = 2'b00,
      GREEN   = 2'b01,
      YELLOW  = 2'b10,
      INVALID = 2'b11
   } light_t;

   // A dwell limit that does not fit the counter could never be satisfied.
   if (YELLOW_CYCLES >= (64'd1 << CNT_W) || MIN_GREEN >= (64'd1 << CNT_W)) begin : g_cfg_check
      $error("semaforo_monitor: dwell limits exceed CNT_W range");
   end

   light_t           prev_a, prev_b;
   logic             prev_valid;
   logic [CNT_W-1:0] dwell_a, dwell_b;

   light_t           cur_a, cur_b;
   logic             enc, conflict, seq, peat, time_bad;
   logic [4:0]       vec;
   logic [2:0]       code;
   logic [CNT_W-1:0] dwell_a_nxt, dwell_b_nxt;
   logic             yr_a;

   function automatic logic seq_bad(input light_t p, input light_t c);
      logic legal;
      legal = (c == p) || (p == GREEN && c == YELLOW) ||
              (p == YELLOW && c == RED) || (p == RED && c == GREEN);
      return (p != INVALID) && (c != INVALID) && !legal;
   endfunction

   function automatic logic [CNT_W-1:0] dwell_next(input light_t p, input light_t c,
                                                   input logic [CNT_W-1:0] d);
      if (c != p)
         return CNT_W'(1);
      else if (d == '1)
         return d;
      else
         return d + CNT_W'(1);
   endfunction

`ifdef MON_TIMING_EN
   localparam logic [CNT_W-1:0] YEL_D = CNT_W'(YELLOW_CYCLES);
   localparam logic [CNT_W-1:0] GRN_D = CNT_W'(MIN_GREEN);

   function automatic logic dwell_bad(input light_t p, input light_t c,
                                      input logic [CNT_W-1:0] d);
      return (c != p) && (((p == YELLOW) && (d != YEL_D)) ||
                          ((p == GREEN) && (d < GRN_D)));
   endfunction
`endif

   always_comb begin
      cur_a    = light_t'(Semaforo_A);
      cur_b    = light_t'(Semaforo_B);
      enc      = (cur_a == INVALID) || (cur_b == INVALID);
      conflict = (cur_a != RED) && (cur_b != RED);
      seq      = prev_valid && (seq_bad(prev_a, cur_a) || seq_bad(prev_b, cur_b));
      peat     = (A_Peatonal && (cur_a != RED)) || (B_Peatonal && (cur_b != RED));
`ifdef MON_TIMING_EN
      time_bad = prev_valid && (dwell_bad(prev_a, cur_a, dwell_a) ||
                                dwell_bad(prev_b, cur_b, dwell_b));
`else
      time_bad = 1'b0;
`endif
      vec = {time_bad, peat, seq, conflict, enc};

      code = 3'd0;
      if (enc)           code = 3'd1;
      else if (conflict) code = 3'd2;
      else if (seq)      code = 3'd3;
      else if (peat)     code = 3'd4;
      else if (time_bad) code = 3'd5;

      dwell_a_nxt = dwell_next(prev_a, cur_a, dwell_a);
      dwell_b_nxt = dwell_next(prev_b, cur_b, dwell_b);
      yr_a        = prev_valid && (prev_a == YELLOW) && (cur_a == RED) && !time_bad;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         prev_a     <= RED;
         prev_b     <= RED;
         prev_valid <= 1'b0;
         dwell_a    <= '0;
         dwell_b    <= '0;
         err        <= 1'b0;
         err_code   <= '0;
         err_vec    <= '0;
         cycles_A   <= '0;
      end else begin
         if (ENB) begin
            prev_a     <= cur_a;
            prev_b     <= cur_b;
            prev_valid <= 1'b1;
            dwell_a    <= dwell_a_nxt;
            dwell_b    <= dwell_b_nxt;
            err_vec    <= vec;
            if (yr_a)
               cycles_A <= cycles_A + CNT_W'(1);
         end
         // A new error beats a simultaneous clear and re-captures the code.
         if (ENB && (vec != '0)) begin
            err <= 1'b1;
            if (!err || clr_err)
               err_code <= code;
         end else if (clr_err) begin
            err      <= 1'b0;
            err_code <= '0;
         end
      end
   end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: directed plan scenarios plus randomized traffic.
module tb_semaforo_monitor;

   localparam int YC = 3;
   localparam int MG = 5;
   localparam int W  = 8;

   logic         CLK = 1'b0;
   logic         RST = 1'b0;
   logic         ENB = 1'b0;
   logic [1:0]   sa = 2'b00, sb = 2'b00;
   logic         ap = 1'b0, bp = 1'b0, clr = 1'b0;
   logic         err;
   logic [2:0]   err_code;
   logic [4:0]   err_vec;
   logic [W-1:0] cycles_A;

   always #5 CLK = ~CLK;

   semaforo_monitor #(.YELLOW_CYCLES(YC), .MIN_GREEN(MG), .CNT_W(W)) dut (
      .CLK(CLK), .RST(RST), .ENB(ENB),
      .Semaforo_A(sa), .Semaforo_B(sb),
      .A_Peatonal(ap), .B_Peatonal(bp), .clr_err(clr),
      .err(err), .err_code(err_code), .err_vec(err_vec), .cycles_A(cycles_A)
   );

   typedef struct {
      int e;
      int c;
      int v;
      int n;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;

   // Reference model state: colours as 0=R 1=G 2=Y 3=invalid
   bit m_pv;
   int m_pa, m_pb, m_da, m_db;
   int m_err, m_code, m_vec, m_cyc;
   int next_col[3] = '{1, 2, 0};

   task automatic chk(input string nm, input int act, input int expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
      end
   endtask

   function automatic void model_reset();
      m_pv = 0; m_pa = 0; m_pb = 0; m_da = 0; m_db = 0;
      m_err = 0; m_code = 0; m_vec = 0; m_cyc = 0;
   endfunction

   function automatic bit illegal_step(input int p, input int c);
      if (p == 3 || c == 3) return 0;
      return (c != p) && (c != next_col[p]);
   endfunction

   function automatic bit dwell_viol(input int p, input int c, input int d);
      if (c == p) return 0;
      if (p == 2) return d != YC;
      if (p == 1) return d < MG;
      return 0;
   endfunction

   function automatic void model_step();
      int ca, cb;
      bit f[5];
      int v, code;
      bit any;
      any = 0;
      if (ENB) begin
         ca = int'(sa); cb = int'(sb);
         f[0] = (ca == 3) || (cb == 3);
         f[1] = (ca != 0) && (cb != 0);
         f[2] = m_pv && (illegal_step(m_pa, ca) || illegal_step(m_pb, cb));
         f[3] = (ap && ca != 0) || (bp && cb != 0);
`ifdef MON_TIMING_EN
         f[4] = m_pv && (dwell_viol(m_pa, ca, m_da) || dwell_viol(m_pb, cb, m_db));
`else
         f[4] = 0;
`endif
         v = 0; code = 0;
         for (int i = 4; i >= 0; i--) begin
            if (f[i]) begin
               v += (1 << i);
               code = i + 1;
            end
         end
         any = (v != 0);
         if (m_pv && m_pa == 2 && ca == 0 && !f[4]) m_cyc = (m_cyc + 1) % 256;
         m_da = (ca != m_pa) ? 1 : ((m_da + 1 > 255) ? 255 : m_da + 1);
         m_db = (cb != m_pb) ? 1 : ((m_db + 1 > 255) ? 255 : m_db + 1);
         m_pa = ca; m_pb = cb; m_pv = 1; m_vec = v;
         if (any) begin
            if (m_err == 0 || clr) m_code = code;
            m_err = 1;
         end
      end
      if (!any && clr) begin
         m_err = 0; m_code = 0;
      end
   endfunction

   task automatic cyc(input logic [1:0] a, input logic [1:0] b, input logic pa = 1'b0,
                      input logic pb = 1'b0, input logic en = 1'b1, input logic cl = 1'b0);
      exp_t x;
      sa = a; sb = b; ap = pa; bp = pb; ENB = en; clr = cl;
      @(posedge CLK);
      model_step();
      x.e = m_err; x.c = m_code; x.v = m_vec; x.n = m_cyc;
      q.push_back(x);
      #1;
   endtask

   task automatic do_reset();
      @(negedge CLK);
      #1;
      RST = 1'b0;
      #1;
      chk("rst_err", int'(err), 0);
      chk("rst_code", int'(err_code), 0);
      chk("rst_vec", int'(err_vec), 0);
      chk("rst_cycles", int'(cycles_A), 0);
      model_reset();
      q.delete();
      @(posedge CLK);
      #2;
      RST = 1'b1;
   endtask

   task automatic run(input logic [1:0] a, input int n);
      for (int i = 0; i < n; i++) cyc(a, 2'b00);
   endtask

   // Scoreboard monitor: one expected response per sampled edge
   always @(negedge CLK) begin
      exp_t x;
      if (RST && q.size() > 0) begin
         x = q.pop_front();
         chk("sb_err", int'(err), x.e);
         chk("sb_code", int'(err_code), x.c);
         chk("sb_vec", int'(err_vec), x.v);
         chk("sb_cycles", int'(cycles_A), x.n);
      end
   end

   initial begin
      model_reset();
      do_reset();

      // Clean A phase
      run(2'b01, 5); run(2'b10, 3); run(2'b00, 4);
      chk("clean_err", int'(err), 0);
      chk("clean_cycles", int'(cycles_A), 1);

      // Direct G->R, then a later PEAT keeps the first code
      run(2'b01, 6); run(2'b00, 1);
      chk("gr_vec", int'(err_vec), 5'b00100);
      chk("gr_code", int'(err_code), 3);
      cyc(2'b01, 2'b00, 1'b1);
      chk("gr_keep_code", int'(err_code), 3);

      // Conflict and encoding priority on first samples
      do_reset();
      cyc(2'b01, 2'b10);
      chk("conf_code", int'(err_code), 2);
      chk("conf_vec", int'(err_vec), 5'b00010);
      do_reset();
      cyc(2'b11, 2'b10);
      chk("enc_code", int'(err_code), 1);

      // PEAT, clear, then clear racing a new conflict
      do_reset();
      cyc(2'b01, 2'b00, 1'b1);
      chk("peat_code", int'(err_code), 4);
      cyc(2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("clr_err", int'(err), 0);
      chk("clr_code", int'(err_code), 0);
      cyc(2'b01, 2'b00, 1'b1);
      cyc(2'b01, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("clr_race_err", int'(err), 1);
      chk("clr_race_code", int'(err_code), 2);

      // Short yellow
      do_reset();
      run(2'b01, 5); run(2'b10, 2); run(2'b00, 1);
`ifdef MON_TIMING_EN
      chk("shorty_vec4", int'(err_vec[4]), 1);
      chk("shorty_code", int'(err_code), 5);
      chk("shorty_cycles", int'(cycles_A), 0);
`else
      chk("shorty_err", int'(err), 0);
      chk("shorty_cycles", int'(cycles_A), 1);
`endif

      // Enable gap mid-yellow, then reset mid-green
      do_reset();
      run(2'b01, 5); run(2'b10, 1);
      for (int i = 0; i < 10; i++)
         cyc(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom), 1'b0);
      run(2'b10, 2); run(2'b00, 1);
      chk("gap_err", int'(err), 0);
      chk("gap_cycles", int'(cycles_A), 1);
      run(2'b01, 2);
      do_reset();
      cyc(2'b10, 2'b00);
      chk("post_rst_noseq", int'(err), 0);
      run(2'b10, 2); run(2'b00, 1);
      chk("post_rst_cycles", int'(cycles_A), 1);

      // Randomized mostly-legal phases with enable gaps
      for (int k = 0; k < 25; k++) begin
         int g, y, r;
         g = $urandom_range(3, 7); y = $urandom_range(2, 4); r = $urandom_range(1, 3);
         for (int i = 0; i < g + y + r; i++)
            cyc((i < g) ? 2'b01 : (i < g + y) ? 2'b10 : 2'b00, 2'b00,
                1'b0, 1'b0, ($urandom_range(0, 9) != 0), ($urandom_range(0, 29) == 0));
      end

      // Fully random traffic with one reset in the middle
      begin
         logic [1:0] a, b;
         a = 2'b00; b = 2'b00;
         for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            if ($urandom_range(0, 99) < 20) a = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 99) < 20) b = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 99) == 0) a = 2'b11;
            cyc(a, b, ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 9) != 0), ($urandom_range(0, 14) == 0));
         end
      end

      repeat (2) @(negedge CLK);
      #1;
      chk("sb_drained", q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/semaforo_monitor.md
Name: semaforo_monitor

Overview:
Passive protocol checker on the output side of the two-way traffic-light controller. Samples both vehicle lights and both pedestrian signals every enabled clock. Flags illegal encodings, conflicting greens, illegal colour sequences, unsafe pedestrian signals and dwell-time violations. Drops into the controller testbench beside the tester, or sits in-system as a safety watchdog.

Parameters:
YELLOW_CYCLES, 3, exact number of enabled samples a light must stay yellow
MIN_GREEN, 5, minimum number of enabled samples a light must stay green
CNT_W, 8, width of dwell counters and cycles_A

Ports:
CLK  in  1  system clock, rising edge
RST  in  1  asynchronous reset, active-low
ENB  in  1  sample enable
Semaforo_A  in  2  light A: 2'b00 red, 2'b01 green, 2'b10 yellow, 2'b11 invalid
Semaforo_B  in  2  light B, same encoding
A_Peatonal  in  1  pedestrian walk, crossing A
B_Peatonal  in  1  pedestrian walk, crossing B
clr_err  in  1  synchronous clear of the sticky error
err  out  1  sticky error flag
err_code  out  3  code of first error since last clear
err_vec  out  5  live per-sample violation flags
cycles_A  out  CNT_W  completed legal A phases (Y->R count)

Behaviour:
- RST low (async): err, err_code, err_vec and cycles_A = 0. prev_valid = 0. Dwell counters = 0. Stored prev_A and prev_B = red.
- ENB=0: all state held and no checks run. err_vec holds its last value. clr_err is still honoured.
- Sampling: on rising CLK with ENB=1, checks are computed from the inputs and stored state. Results are registered on that edge and visible after it (1-cycle latency).
- err_vec bits:
  - [0] ENC: either light == 2'b11.
  - [1] CONFLICT: Semaforo_A != red and Semaforo_B != red.
  - [2] SEQ: per light, prev->cur not in {hold, G->Y, Y->R, R->G}. Suppressed when prev or cur is 2'b11 (ENC covers that case).
  - [3] PEAT: A_Peatonal=1 while Semaforo_A != red, or B_Peatonal=1 while Semaforo_B != red.
  - [4] TIME: a light leaves yellow with dwell != YELLOW_CYCLES, or leaves green with dwell < MIN_GREEN.
- First enabled sample after reset: ENC, CONFLICT and PEAT are checked. SEQ and TIME are skipped. The sample loads prev_A, prev_B and sets prev_valid=1.
- Dwell counter per light:
  - Loads 1 when cur != prev (including into or out of 2'b11).
  - Increments when cur == prev.
  - Saturates at 2^CNT_W-1.
- err:
  - Set when any err_vec bit is set on a sample.
  - Cleared only by clr_err or reset.
  - clr_err and a new error in the same cycle: the error wins. err stays 1 and err_code takes the new code.
- err_code:
  - Loaded only when err goes 0->1, or on the clr_err+error case above.
  - Value is the highest-priority set bit: ENC=1, CONFLICT=2, SEQ=3, PEAT=4, TIME=5.
  - clr_err alone zeroes err_code.
- cycles_A: increments on each A Y->R transition whose sample has err_vec[4]=0. Wraps modulo 2^CNT_W.
- Reset mid-phase: all history is lost. The next enabled sample is treated as a first sample.

Optional Feature:
MON_TIMING_EN.
- Defined: dwell-based TIME checking as specified above. err_vec[4] and code 5 are active.
- Undefined: TIME logic is not compiled. err_vec[4] is tied 0, code 5 is never produced, and cycles_A counts every A Y->R.
- Dwell counters still exist either way.

Test Plan:
- A: G x5, Y x3, R x4, with B red and pedestrians 0 -> err=0, err_vec=0, cycles_A=1.
- A direct G->R after 6 greens -> err_vec=5'b00100 on that sample, err=1, err_code=3. A later PEAT error leaves err_code=3.
- Semaforo_A=green and Semaforo_B=yellow on the same sample -> err_vec[1]=1, err_code=2. If Semaforo_A=2'b11 on that same sample -> err_code=1.
- A yellow for only 2 samples then red, with MON_TIMING_EN defined -> err_vec[4]=1, err_code=5, cycles_A unchanged. Without the macro -> err=0, cycles_A+1.
- A_Peatonal=1 with A green -> err_code=4. Then clr_err=1 with clean inputs -> err=0, err_code=0 next cycle. Then clr_err and a CONFLICT on the same edge -> err=1, err_code=2.
- ENB=0 for 10 cycles mid-yellow (after 1 yellow sample), then 2 more yellow samples, then red -> no TIME error. RST pulsed low mid-green -> all outputs 0 immediately, and the next sample is not SEQ-checked.
